// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounces the board buttons and sequences the stopwatch datapath (IDLE/RUN/PAUSE).
// Defining STOPWATCH_ADJUST_EN adds the ADJUST state with its adj_mode/adj_sel/adj_inc outputs.
module stopwatch_ctrl #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 1,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_adj,
  input  logic       btn_sel,
  output logic       count_en,
  output logic       clear,
  output logic       running,
  output logic       paused,
  output logic       adj_mode,
  output logic       adj_sel,
  output logic       adj_inc,
  output logic       blink,
  output logic [1:0] state
);
  localparam int DIV    = CLK_HZ / TICK_HZ;
  localparam int HALF   = DIV / 2;
  localparam int DIV_W  = $clog2(DIV);
  localparam int HALF_W = $clog2(HALF + 1);
  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);

  localparam int B_START = 0;
  localparam int B_CLEAR = 1;
`ifdef STOPWATCH_ADJUST_EN
  localparam int B_ADJ = 2;
  localparam int B_SEL = 3;
  localparam int NB    = 4;
`else
  localparam int NB    = 2;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSE  = 2'b10,
    ADJUST = 2'b11
  } state_t;

  logic [NB-1:0] btn_raw;
`ifdef STOPWATCH_ADJUST_EN
  assign btn_raw = {btn_sel, btn_adj, btn_clear, btn_start};
`else
  logic unused_adj_btns;
  assign btn_raw         = {btn_clear, btn_start};
  assign unused_adj_btns = btn_adj ^ btn_sel;
`endif

  logic [NB-1:0]    sync1_q, sync2_q, deb_q, deb_prev_q, press;
  logic [DEB_W-1:0] deb_cnt_q [NB];

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      // NOTE: the per-button counters are plain flops, not a RAM, so they reset with everything else.
      for (int i = 0; i < NB; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < NB; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
          deb_q[i]     <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Rising edge of the debounced level only; releases are silent.
  assign press = deb_q & ~deb_prev_q;

  logic clr_p, st_p;
  assign clr_p = press[B_CLEAR];
  assign st_p  = press[B_START] & ~press[B_CLEAR];
`ifdef STOPWATCH_ADJUST_EN
  logic adj_p, sel_p, sel_d, inc_d;
  assign adj_p = press[B_ADJ] & ~press[B_CLEAR] & ~press[B_START];
  assign sel_p = press[B_SEL] & ~(press[B_CLEAR] | press[B_START] | press[B_ADJ]);
`endif

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             wrap, count_en_d, clear_d;

  assign wrap  = (div_q == DIV_W'(DIV - 1));
  assign state = state_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    div_d      = div_q;
    clear_d    = 1'b0;
    count_en_d = (state_q == RUN) && wrap && !clr_p;
`ifdef STOPWATCH_ADJUST_EN
    sel_d      = adj_sel;
    inc_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (clr_p) begin
          clear_d = 1'b1;
          div_d   = '0;
        end else if (st_p) begin
          state_d = RUN;
          div_d   = '0;
        end
`ifdef STOPWATCH_ADJUST_EN
        else if (adj_p) begin
          state_d = ADJUST;
          sel_d   = 1'b0;
        end
`endif
      end
      RUN: begin
        div_d = wrap ? '0 : div_q + 1'b1;
        if (clr_p) begin
          state_d = IDLE;
          clear_d = 1'b1;
          div_d   = '0;
        end else if (st_p) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (clr_p) begin
          state_d = IDLE;
          clear_d = 1'b1;
          div_d   = '0;
        end else if (st_p) begin
          state_d = RUN;  // divider kept: resume mid-period
        end
`ifdef STOPWATCH_ADJUST_EN
        else if (adj_p) begin
          state_d = ADJUST;
          sel_d   = 1'b0;
        end
`endif
      end
      ADJUST: begin
`ifdef STOPWATCH_ADJUST_EN
        if (clr_p) begin
          state_d = IDLE;
          clear_d = 1'b1;
          div_d   = '0;
          sel_d   = 1'b0;
        end else if (st_p) begin
          inc_d = 1'b1;
        end else if (adj_p) begin
          state_d = PAUSE;
        end else if (sel_p) begin
          sel_d = ~adj_sel;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      count_en <= 1'b0;
      clear    <= 1'b0;
      running  <= 1'b0;
      paused   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      count_en <= count_en_d;
      clear    <= clear_d;
      running  <= (state_d == RUN);
      paused   <= (state_d == PAUSE);
    end
  end

`ifdef STOPWATCH_ADJUST_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      adj_mode <= 1'b0;
      adj_sel  <= 1'b0;
      adj_inc  <= 1'b0;
    end else begin
      adj_mode <= (state_d == ADJUST);
      adj_sel  <= sel_d;
      adj_inc  <= inc_d;
    end
  end
`else
  assign adj_mode = 1'b0;
  assign adj_sel  = 1'b0;
  assign adj_inc  = 1'b0;
`endif

  logic [HALF_W-1:0] blink_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_cnt_q <= '0;
      blink       <= 1'b0;
    end else if (blink_cnt_q == HALF_W'(HALF - 1)) begin
      blink_cnt_q <= '0;
      blink       <= ~blink;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (CLK_HZ=20, TICK_HZ=1, DEB_CYCLES=3): per-cycle model compare
// plus directed literal checks. Covers the ADJUST feature when STOPWATCH_ADJUST_EN is defined.
module tb_stopwatch_ctrl;
  localparam int DIV  = 20;
  localparam int HALF = 10;
  localparam int DEB  = 3;
`ifdef STOPWATCH_ADJUST_EN
  localparam bit ADJ_EN = 1'b1;
`else
  localparam bit ADJ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, btn_start, btn_clear, btn_adj, btn_sel;
  logic count_en, clear, running, paused, adj_mode, adj_sel, adj_inc, blink;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;
  int ce_seen  = 0;
  int inc_seen = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.CLK_HZ(20), .TICK_HZ(1), .DEB_CYCLES(3)) dut (
    .clk(clk), .reset(reset),
    .btn_start(btn_start), .btn_clear(btn_clear), .btn_adj(btn_adj), .btn_sel(btn_sel),
    .count_en(count_en), .clear(clear), .running(running), .paused(paused),
    .adj_mode(adj_mode), .adj_sel(adj_sel), .adj_inc(adj_inc), .blink(blink), .state(state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a button level is accepted once the last DEB synchronised samples all
  // disagree with it; run time is tracked as elapsed RUN cycles modulo the tick period.
  logic [1:0]  m_state;
  int          m_run, m_cyc;
  logic        m_ce, m_clr, m_inc, m_sel;
  logic [3:0]  m_pend, m_lvl;
  logic [15:0] m_hist [4];

  always @(posedge clk) begin : model
    logic [1:0]  st;
    int          run, cyc;
    logic        ce, clr, inc, sel, flip;
    logic        do_clr, do_st, do_adj, do_sel;
    logic [3:0]  raw, p, lvl, pend;
    logic [15:0] h [4];
    raw = {btn_sel, btn_adj, btn_clear, btn_start};
    if (!reset) begin
      st = 2'd0; run = 0; cyc = 0; ce = 0; clr = 0; inc = 0; sel = 0; pend = '0; lvl = '0;
      for (int b = 0; b < 4; b++) h[b] = '0;
    end else begin
      st = m_state; run = m_run; cyc = m_cyc + 1; sel = m_sel; lvl = m_lvl; p = m_pend;
      ce = 0; clr = 0; inc = 0;
      for (int b = 0; b < 4; b++) h[b] = m_hist[b];
      do_clr = p[1];
      do_st  = p[0] && !p[1];
      do_adj = ADJ_EN && p[2] && !p[1] && !p[0];
      do_sel = ADJ_EN && p[3] && !(p[0] || p[1] || p[2]);
      if (st == 2'd1) begin
        run = (run + 1) % DIV;
        ce  = (run == 0) && !do_clr;
      end
      if (do_clr) begin
        clr = 1; run = 0; st = 2'd0;
        if (m_state == 2'd3) sel = 0;
      end else begin
        case (m_state)
          2'd0: if (do_st) begin st = 2'd1; run = 0; end
                else if (do_adj) begin st = 2'd3; sel = 0; end
          2'd1: if (do_st) st = 2'd2;
          2'd2: if (do_st) st = 2'd1;
                else if (do_adj) begin st = 2'd3; sel = 0; end
          default: if (do_st) inc = 1;
                   else if (do_adj) st = 2'd2;
                   else if (do_sel) sel = ~sel;
        endcase
      end
      pend = '0;
      for (int b = 0; b < 4; b++) begin
        h[b] = {h[b][14:0], raw[b]};
        flip = 1;
        for (int i = 2; i < DEB + 2; i++) if (h[b][i] == lvl[b]) flip = 0;
        if (flip) begin
          lvl[b]  = ~lvl[b];
          pend[b] = lvl[b];
        end
      end
    end
    m_state <= st; m_run <= run; m_cyc <= cyc; m_ce <= ce; m_clr <= clr; m_inc <= inc;
    m_sel <= sel; m_pend <= pend; m_lvl <= lvl;
    for (int b = 0; b < 4; b++) m_hist[b] <= h[b];
  end

  always @(negedge clk) begin
    check("state", state, m_state);
    check("count_en", count_en, m_ce);
    check("clear", clear, m_clr);
    check("running", running, m_state == 2'd1);
    check("paused", paused, m_state == 2'd2);
    check("adj_mode", adj_mode, m_state == 2'd3);
    check("adj_sel", adj_sel, m_sel);
    check("adj_inc", adj_inc, m_inc);
    check("blink", blink, (m_cyc / HALF) % 2);
    if (count_en) ce_seen++;
    if (adj_inc) inc_seen++;
  end

  task automatic wait_cnt_en(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (count_en !== 1'b1 && n < 200);
  endtask

  task automatic wait_state(input logic [1:0] s, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (state !== s && n < 60);
  endtask

  task automatic push(input logic [3:0] m);
    {btn_sel, btn_adj, btn_clear, btn_start} = m;
    repeat (10) @(negedge clk);
    {btn_sel, btn_adj, btn_clear, btn_start} = 4'b0000;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, c0;
    reset = 1'b0;
    {btn_sel, btn_adj, btn_clear, btn_start} = 4'b0000;
    repeat (2) @(negedge clk);
    check("rst_state", state, 2'b00);
    check("rst_outputs", {count_en, clear, running, paused, adj_mode, adj_sel, adj_inc, blink}, 8'h00);
    reset = 1'b1;

    // Blink period after reset release.
    repeat (9) @(negedge clk);
    check("blink_before_10", blink, 1'b0);
    @(negedge clk);
    check("blink_at_10", blink, 1'b1);
    repeat (10) @(negedge clk);
    check("blink_at_20", blink, 1'b0);

    // Start latency and tick period.
    btn_start = 1'b1;
    repeat (5) @(negedge clk);
    check("start_edge5", state, 2'b00);
    @(negedge clk);
    check("start_edge6", state, 2'b01);
    repeat (4) @(negedge clk);
    btn_start = 1'b0;
    wait_cnt_en(n);
    check("first_tick", n + 4, 20);
    wait_cnt_en(n);
    check("tick_period", n, 20);

    // Glitch is rejected; then pause aligned 6 cycles after a tick, resume.
    btn_start = 1'b1;
    repeat (2) @(negedge clk);
    btn_start = 1'b0;
    repeat (8) @(negedge clk);
    check("glitch_ignored", state, 2'b01);
    wait_cnt_en(n);
    check("tick_after_glitch", n, 10);
    btn_start = 1'b1;
    repeat (6) @(negedge clk);
    check("pause_state", state, 2'b10);
    c0 = ce_seen;
    repeat (4) @(negedge clk);
    btn_start = 1'b0;
    repeat (15) @(negedge clk);
    check("pause_no_tick", ce_seen - c0, 0);
    btn_start = 1'b1;
    wait_state(2'b01, n);
    check("resume_latency", n, 6);
    repeat (4) @(negedge clk);
    btn_start = 1'b0;
    wait_cnt_en(n);
    check("resume_remaining", n + 4, 14);

    // Clear and start together in RUN: clear wins.
    btn_start = 1'b1;
    btn_clear = 1'b1;
    repeat (5) @(negedge clk);
    check("both_edge5", state, 2'b01);
    @(negedge clk);
    check("both_state", state, 2'b00);
    check("both_clear", clear, 1'b1);
    check("both_no_pause", paused, 1'b0);
    @(negedge clk);
    check("clear_one_cycle", clear, 1'b0);
    repeat (3) @(negedge clk);
    btn_start = 1'b0;
    btn_clear = 1'b0;
    repeat (12) @(negedge clk);

    // Reset mid-RUN with divider at 12.
    btn_start = 1'b1;
    wait_state(2'b01, n);
    check("run2_latency", n, 6);
    repeat (4) @(negedge clk);
    btn_start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrun_rst_state", state, 2'b00);
    check("midrun_rst_outputs", {count_en, clear, running, blink}, 4'h0);
    reset = 1'b1;
    btn_start = 1'b1;
    wait_state(2'b01, n);
    check("run3_latency", n, 6);
    repeat (4) @(negedge clk);
    btn_start = 1'b0;
    wait_cnt_en(n);
    check("tick_after_reset", n + 4, 20);

    // Adjust mode from PAUSE.
    push(4'b0001);
    check("adj_pause", state, 2'b10);
    push(4'b0100);
`ifdef STOPWATCH_ADJUST_EN
    check("adj_enter", state, 2'b11);
    check("adj_enter_sel", {adj_mode, adj_sel}, 2'b10);
    push(4'b1000);
    check("adj_sel_toggle", adj_sel, 1'b1);
    c0 = inc_seen;
    repeat (3) push(4'b0001);
    check("adj_inc_count", inc_seen - c0, 3);
    check("adj_stays", state, 2'b11);
    push(4'b0100);
    check("adj_exit", state, 2'b10);
    push(4'b0100);
    check("adj_reenter_sel", {state, adj_sel}, 3'b110);
    push(4'b1000);
    push(4'b0010);
    check("adj_clear_state", state, 2'b00);
    check("adj_clear_sel", adj_sel, 1'b0);
`else
    check("adj_ignored", state, 2'b10);
    c0 = inc_seen;
    push(4'b1000);
    push(4'b0001);
    check("adj_outputs_zero", {adj_mode, adj_sel, inc_seen - c0}, 0);
    push(4'b0010);
    check("pause_clear_state", state, 2'b00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
